// File: rtl/station_timer_ctrl.sv
// Station sequencer timers: dwell/load accumulation, line phase and gear phase, with sticky enable-conflict flag.
// Latency: all outputs registered; pulses appear on the edge the terminal count is reached.
// Backpressure: none; enables are levels, and a conflict freezes every counter for that edge.
module station_timer_ctrl #(
    parameter int unsigned DWELL_CYC = 100,
    parameter int unsigned LINE_CYC  = 50,
    parameter int unsigned GEAR_CYC  = 30,
    parameter int unsigned MAX_LOAD  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_acc,
    input  logic       en_line_timer,
    input  logic       en_gear_timer,
    input  logic       en_sensor,
    input  logic       detect,
    output logic       ready,
    output logic       line_end,
    output logic       gear_end,
    output logic [7:0] load_count,
    output logic       err
);

    localparam logic [15:0] DWELL_MAX = 16'(DWELL_CYC);
    localparam logic [15:0] LINE_MAX  = 16'(LINE_CYC);
    localparam logic [15:0] GEAR_MAX  = 16'(GEAR_CYC);
    localparam logic [7:0]  LOAD_MAX  = 8'(MAX_LOAD);

    logic        det_q;
    logic [15:0] dwell_cnt;
    logic        acc_done;
    logic [15:0] line_cnt;
    logic        line_done;
    logic [15:0] gear_cnt;
    logic        gear_done;

    logic        conflict;
    logic        det_evt;
    logic [15:0] dwell_nxt;
    logic [7:0]  load_nxt;
    logic        acc_hit;
    logic [15:0] line_nxt;
    logic [15:0] gear_nxt;

    assign conflict  = (en_acc & en_line_timer) | (en_acc & en_gear_timer)
                     | (en_line_timer & en_gear_timer);
    assign det_evt   = detect & ~det_q & en_sensor;
    assign dwell_nxt = (dwell_cnt == DWELL_MAX) ? dwell_cnt : dwell_cnt + 16'd1;
    assign load_nxt  = (det_evt && (load_count != LOAD_MAX)) ? load_count + 8'd1 : load_count;
    // Either terminal condition completes the dwell; acc_done keeps it to a single pulse.
    assign acc_hit   = (dwell_nxt == DWELL_MAX) || (load_nxt == LOAD_MAX);
    assign line_nxt  = line_cnt + 16'd1;
    assign gear_nxt  = gear_cnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_q      <= 1'b0;
            dwell_cnt  <= '0;
            load_count <= '0;
            acc_done   <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
        end else begin
            det_q <= detect;
            ready <= 1'b0;
            if (conflict) begin
                err <= 1'b1;
            end
            if (!en_acc) begin
                dwell_cnt  <= '0;
                load_count <= '0;
                acc_done   <= 1'b0;
            end else if (!conflict) begin
                dwell_cnt  <= dwell_nxt;
                load_count <= load_nxt;
                if (acc_hit) begin
                    acc_done <= 1'b1;
                    ready    <= ~acc_done;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_cnt  <= '0;
            line_done <= 1'b0;
            line_end  <= 1'b0;
        end else begin
            line_end <= 1'b0;
            if (!en_line_timer) begin
                line_cnt  <= '0;
                line_done <= 1'b0;
            end else if (!conflict && !line_done) begin
                line_cnt <= line_nxt;
                if (line_nxt == LINE_MAX) begin
                    line_done <= 1'b1;
                    line_end  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gear_cnt  <= '0;
            gear_done <= 1'b0;
            gear_end  <= 1'b0;
        end else begin
            gear_end <= 1'b0;
            if (!en_gear_timer) begin
                gear_cnt  <= '0;
                gear_done <= 1'b0;
            end else if (!conflict && !gear_done) begin
                gear_cnt <= gear_nxt;
                if (gear_nxt == GEAR_MAX) begin
                    gear_done <= 1'b1;
                    gear_end  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_station_timer_ctrl.sv
// Bench for station_timer_ctrl: two instances (short and long dwell) against an event-count model.
module tb_station_timer_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_acc = 1'b0;
    logic en_line_timer = 1'b0;
    logic en_gear_timer = 1'b0;
    logic en_sensor = 1'b0;
    logic detect = 1'b0;

    logic       ready_a, line_end_a, gear_end_a, err_a;
    logic [7:0] load_a;
    logic       ready_b, line_end_b, gear_end_b, err_b;
    logic [7:0] load_b;

    always #5 clk = ~clk;

    station_timer_ctrl #(.DWELL_CYC(4), .LINE_CYC(5), .GEAR_CYC(2), .MAX_LOAD(3)) dut_a (
        .clk(clk), .reset(reset), .en_acc(en_acc), .en_line_timer(en_line_timer),
        .en_gear_timer(en_gear_timer), .en_sensor(en_sensor), .detect(detect),
        .ready(ready_a), .line_end(line_end_a), .gear_end(gear_end_a),
        .load_count(load_a), .err(err_a)
    );

    station_timer_ctrl #(.DWELL_CYC(100), .LINE_CYC(5), .GEAR_CYC(2), .MAX_LOAD(3)) dut_b (
        .clk(clk), .reset(reset), .en_acc(en_acc), .en_line_timer(en_line_timer),
        .en_gear_timer(en_gear_timer), .en_sensor(en_sensor), .detect(detect),
        .ready(ready_b), .line_end(line_end_b), .gear_end(gear_end_b),
        .load_count(load_b), .err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts enabled, non-conflicting edges and detect events as unbounded integers.
    int P_D [2] = '{4, 100};
    int P_M [2] = '{3, 3};
    int P_L [2] = '{5, 5};
    int P_G [2] = '{2, 2};
    int acc_n [2];
    int det_n [2];
    int line_n [2];
    int gear_n [2];
    bit fired [2];
    bit m_err [2];
    bit m_ready [2];
    bit m_line [2];
    bit m_gear [2];
    int m_load [2];
    bit m_prev;
    bit m_conf;
    bit m_ev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                acc_n[i] = 0; det_n[i] = 0; line_n[i] = 0; gear_n[i] = 0;
                fired[i] = 0; m_err[i] = 0; m_ready[i] = 0; m_line[i] = 0;
                m_gear[i] = 0; m_load[i] = 0;
            end
            m_prev = 0;
        end else begin
            m_conf = (int'(en_acc) + int'(en_line_timer) + int'(en_gear_timer)) >= 2;
            m_ev   = detect && !m_prev && en_sensor;
            for (int i = 0; i < 2; i++) begin
                m_ready[i] = 0; m_line[i] = 0; m_gear[i] = 0;
                if (m_conf) m_err[i] = 1;
                if (!en_acc) begin
                    acc_n[i] = 0; det_n[i] = 0; fired[i] = 0;
                end else if (!m_conf) begin
                    acc_n[i]++;
                    if (m_ev) det_n[i]++;
                    if (!fired[i] && (acc_n[i] >= P_D[i] || det_n[i] >= P_M[i])) begin
                        m_ready[i] = 1;
                        fired[i]   = 1;
                    end
                end
                m_load[i] = (det_n[i] < P_M[i]) ? det_n[i] : P_M[i];
                if (!en_line_timer) line_n[i] = 0;
                else if (!m_conf) begin
                    line_n[i]++;
                    m_line[i] = (line_n[i] == P_L[i]);
                end
                if (!en_gear_timer) gear_n[i] = 0;
                else if (!m_conf) begin
                    gear_n[i]++;
                    m_gear[i] = (gear_n[i] == P_G[i]);
                end
            end
            m_prev = detect;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("a.ready",    ready_a,    m_ready[0]);
        chk("a.line_end", line_end_a, m_line[0]);
        chk("a.gear_end", gear_end_a, m_gear[0]);
        chk("a.load",     load_a,     m_load[0]);
        chk("a.err",      err_a,      m_err[0]);
        chk("b.ready",    ready_b,    m_ready[1]);
        chk("b.line_end", line_end_b, m_line[1]);
        chk("b.gear_end", gear_end_b, m_gear[1]);
        chk("b.load",     load_b,     m_load[1]);
        chk("b.err",      err_b,      m_err[1]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick();
        tick();
        chk("rst.ready", ready_a, 0);
        chk("rst.load",  load_a, 0);
        chk("rst.err",   err_a, 0);
        chk("rst.line",  line_end_a, 0);
        reset = 1'b0;
        tick();

        // Dwell completes after edge 4, no repeat while en_acc stays high.
        en_acc = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("dwell.ready", ready_a, (k == 4) ? 1 : 0);
            chk("dwell.load", load_a, 0);
        end
        en_acc = 1'b0;
        tick();

        // Early dispatch on the third passenger, count saturates.
        en_acc = 1'b1;
        en_sensor = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            detect = 1'b1;
            tick();
            chk("load.count", load_b, (p < 3) ? p : 3);
            chk("load.ready", ready_b, (p == 3) ? 1 : 0);
            detect = 1'b0;
            tick();
            chk("load.ready_lo", ready_b, 0);
        end
        en_acc = 1'b0;
        tick();

        // Detects ignored without sensor qualification or without en_acc.
        en_acc = 1'b1;
        en_sensor = 1'b0;
        for (int p = 0; p < 2; p++) begin
            detect = 1'b1; tick();
            detect = 1'b0; tick();
            chk("nosens.load", load_b, 0);
            chk("nosens.ready", ready_b, 0);
        end
        en_acc = 1'b0;
        en_sensor = 1'b1;
        for (int p = 0; p < 2; p++) begin
            detect = 1'b1; tick();
            chk("noacc.load", load_b, 0);
            detect = 1'b0; tick();
        end

        // Line phase then gear phase.
        en_line_timer = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("line.end", line_end_a, (k == 5) ? 1 : 0);
        end
        en_line_timer = 1'b0;
        en_gear_timer = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("gear.end", gear_end_a, (k == 2) ? 1 : 0);
        end
        en_gear_timer = 1'b0;
        tick();
        chk("noconf.err", err_a, 0);

        // Conflict freezes the line counter for one edge and latches err.
        en_line_timer = 1'b1;
        tick();
        tick();
        en_acc = 1'b1;
        tick();
        chk("conf.err", err_a, 1);
        chk("conf.line_end", line_end_a, 0);
        chk("conf.ready", ready_a, 0);
        en_acc = 1'b0;
        tick();
        chk("conf.line3", line_end_a, 0);
        tick();
        chk("conf.line4", line_end_a, 0);
        tick();
        chk("conf.line5", line_end_a, 1);
        en_line_timer = 1'b0;
        tick();
        chk("conf.sticky", err_a, 1);

        // Conflict freezes the dwell counter too.
        en_acc = 1'b1;
        tick();
        tick();
        en_gear_timer = 1'b1;
        tick();
        chk("aconf.ready", ready_a, 0);
        en_gear_timer = 1'b0;
        tick();
        chk("aconf.ready3", ready_a, 0);
        tick();
        chk("aconf.ready4", ready_a, 1);
        en_acc = 1'b0;
        tick();

        // Mixed traffic checked only by the model.
        begin
            int mode;
            int len;
            for (int seg = 0; seg < 20; seg++) begin
                mode = $urandom_range(0, 5);
                len  = $urandom_range(1, 12);
                en_acc        = (mode == 1 || mode == 4 || mode == 5);
                en_line_timer = (mode == 2 || mode == 5);
                en_gear_timer = (mode == 3);
                en_sensor     = 1'($urandom_range(0, 1));
                for (int c = 0; c < len; c++) begin
                    detect = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        en_acc = 1'b0; en_line_timer = 1'b0; en_gear_timer = 1'b0;
        en_sensor = 1'b0; detect = 1'b0;
        tick();

        // Reset mid-line at count 3 abandons the count.
        en_line_timer = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mrst.line_end", line_end_a, 0);
        chk("mrst.ready", ready_a, 0);
        chk("mrst.gear_end", gear_end_a, 0);
        chk("mrst.load", load_a, 0);
        chk("mrst.err", err_a, 0);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("mrst.relaunch", line_end_a, (k == 5) ? 1 : 0);
        end
        en_line_timer = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
